// File: rtl/dmem_bus_bridge_pkg.sv
// Shared definitions for the CPU data-port bus bridges: state encodings and error-return defaults.
// Kept generic so a future instruction-side bridge can reuse the same encodings.
package dmem_bus_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;
  localparam int          TIMEOUT_DEFAULT  = 255;

  function automatic logic misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/bus_timeout_cnt.sv
// Saturating cycle counter for the bridge timeout; expire pulses on the TIMEOUT-th enabled cycle.
// TIMEOUT = 0 disables expiry entirely.
module bus_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [W-1:0] LAST = (TIMEOUT > 0) ? W'(TIMEOUT - 1) : '0;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expire = (TIMEOUT != 0) && en && (cnt == LAST);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Bridges the CPU single-cycle MEM-stage data port onto a req/gnt/rvalid bus, stalling the pipeline meanwhile.
// Optional DMEM_BUS_BRIDGE_MISALIGN_EN: misaligned accesses skip the bus and complete with ERR_DATA.
module dmem_bus_bridge
  import dmem_bus_bridge_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                TIMEOUT  = TIMEOUT_DEFAULT,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_err,
  output logic              err_sticky,
  output state_t            dbg_state
);

`ifdef DMEM_BUS_BRIDGE_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

  state_t state;
  logic   acc;
  logic   expire;

  // Handshake: bus_req stays high until the cycle bus_gnt is seen; a read then waits for bus_rvalid
  // (possibly in the grant cycle itself). bus_err is qualified by bus_gnt for writes, bus_rvalid for reads.
  assign acc       = cpu_re | cpu_we;
  assign cpu_stall = acc && (state != ST_DONE);
  assign dbg_state = state;

  bus_timeout_cnt #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ST_IDLE),
    .en     ((state == ST_REQ) || (state == ST_WAIT)),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bus_req    <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      cpu_rdata  <= '0;
      err_sticky <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acc) begin
            if (MISALIGN_EN && misaligned(cpu_addr[1:0])) begin
              cpu_rdata  <= ERR_DATA;
              err_sticky <= 1'b1;
              state      <= ST_DONE;
            end else begin
              // A simultaneous load+store is a store.
              bus_req   <= 1'b1;
              bus_we    <= cpu_we;
              bus_addr  <= cpu_addr;
              bus_wdata <= cpu_wdata;
              state     <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (bus_we) begin
              if (bus_err) err_sticky <= 1'b1;
              state <= ST_DONE;
            end else if (bus_rvalid) begin
              cpu_rdata <= bus_err ? ERR_DATA : bus_rdata;
              if (bus_err) err_sticky <= 1'b1;
              state <= ST_DONE;
            end else begin
              state <= ST_WAIT;
            end
          end else if (expire) begin
            bus_req    <= 1'b0;
            cpu_rdata  <= ERR_DATA;
            err_sticky <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_WAIT: begin
          if (bus_rvalid) begin
            cpu_rdata <= bus_err ? ERR_DATA : bus_rdata;
            if (bus_err) err_sticky <= 1'b1;
            state <= ST_DONE;
          end else if (expire) begin
            cpu_rdata  <= ERR_DATA;
            err_sticky <= 1'b1;
            state      <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Bench for dmem_bus_bridge: randomized CPU accesses against a bus responder and a memory-level model.
// Honours DMEM_BUS_BRIDGE_MISALIGN_EN for the misaligned-store expectation.
module tb_dmem_bus_bridge;
  import dmem_bus_bridge_pkg::*;

  localparam int          T   = 8;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;
`ifdef DMEM_BUS_BRIDGE_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_re, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
  logic        err_sticky;
  state_t      dbg_state;

  dmem_bus_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T), .ERR_DATA(ERR)) dut (
    .clk(clk), .reset(reset),
    .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata), .bus_err(bus_err),
    .err_sticky(err_sticky), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // {stall cycles[40:33], err_sticky[32], cpu_rdata[31:0]} expected at each completion
  logic [40:0] exp_q[$];

  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] last_m = '0;
  bit          sticky_m = 1'b0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0F0F_3C3C;
  endfunction

  function automatic logic [31:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_word(a);
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    bus_mem[a] = d;
    ref_mem[a] = d;
  endtask

  // Monitor: a completion is a cycle where the CPU presents an access and is not stalled.
  int stall_cnt = 0;
  always @(negedge clk) begin : monitor
    logic [40:0] e;
    if (!reset) begin
      stall_cnt = 0;
    end else if (cpu_re | cpu_we) begin
      if (cpu_stall) begin
        stall_cnt++;
      end else begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("cpu_rdata", cpu_rdata, e[31:0]);
          chk("err_sticky", err_sticky, e[32]);
          chk("stall_cycles", stall_cnt, e[40:33]);
        end
        stall_cnt = 0;
      end
    end
  end

  // ---------------- driver ----------------
  // mode: 0 normal, 1 bus_err, 2 never granted, 3 granted but no rvalid (then a late rvalid),
  // 4 read aborted by reset in the first wait cycle. g = extra REQ cycles before gnt, r = gnt->rvalid.
  task automatic run_access(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                            input int g, input int r, input int mode_in);
    bit is_wr, is_rd, mis, tmo, err, done;
    int mode, lat, exp_req, exp_wait, cyc, n_req, n_wait;
    logic [31:0] gnt_addr;
    mode  = mode_in;
    is_wr = wr;
    is_rd = rd && !wr;
    if (is_wr && mode >= 3) mode = 2;
    mis = MIS_EN && (addr[1:0] != 2'b00);
    tmo = !mis && (mode == 2 || mode == 3);
    err = !mis && (mode == 1);
    gnt_addr = '0;
    lat = 0; exp_req = 0; exp_wait = 0;

    if (mode != 4) begin
      if (mis) begin
        lat = 1; last_m = ERR; sticky_m = 1'b1;
      end else if (tmo) begin
        lat = 1 + T;
        exp_req  = (mode == 2) ? T : g + 1;
        exp_wait = (mode == 2) ? 0 : T - (g + 1);
        last_m = ERR; sticky_m = 1'b1;
      end else begin
        lat = 2 + g + (is_rd ? r : 0);
        exp_req  = g + 1;
        exp_wait = is_rd ? r : 0;
        if (is_rd) last_m = err ? ERR : ref_rd(addr);
        else if (!err) ref_mem[addr] = wdata;
        if (err) sticky_m = 1'b1;
      end
      exp_q.push_back({8'(lat), sticky_m, last_m});
    end

    cpu_re = rd; cpu_we = wr; cpu_addr = addr; cpu_wdata = wdata;
    cyc = 0; done = 1'b0; n_req = 0; n_wait = 0;
    while (!done && cyc < 40) begin
      bus_gnt = !mis && (mode != 2) && (cyc == 1 + g);
      if (bus_gnt) begin
        gnt_addr = bus_addr;
        chk("bus_addr", bus_addr, addr);
        chk("bus_we", bus_we, is_wr);
        if (is_wr) chk("bus_wdata", bus_wdata, wdata);
        if (is_wr && !err) bus_mem[bus_addr] = bus_wdata;
      end
      bus_rvalid = is_rd && !mis && (mode <= 1) && (cyc == 1 + g + r);
      bus_err    = err && ((is_wr && bus_gnt) || (is_rd && bus_rvalid));
      bus_rdata  = bus_rvalid ? bus_rd(gnt_addr) : $urandom();
      if (mode == 4 && cyc == 2 + g) begin
        #1;
        reset = 1'b0; cpu_re = 1'b0; cpu_we = 1'b0; bus_gnt = 1'b0;
        #1;
        chk("rst_bus_req", bus_req, 1'b0);
        chk("rst_cpu_stall", cpu_stall, 1'b0);
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_err_sticky", err_sticky, 1'b0);
        @(posedge clk);
        #2 reset = 1'b1;
        sticky_m = 1'b0; last_m = '0;
        @(posedge clk);
        #1;
        return;
      end
      @(negedge clk);
      if (bus_req) n_req++;
      if (dbg_state == ST_WAIT) n_wait++;
      if (!cpu_stall) done = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
    end
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
    cpu_re = 1'b0; cpu_we = 1'b0;
    chk("done_seen", done, 1'b1);
    chk("req_cycles", n_req, exp_req);
    chk("wait_cycles", n_wait, exp_wait);
    if (mode == 3) begin
      bus_rvalid = 1'b1;
      bus_rdata  = $urandom();
      @(posedge clk);
      #1;
      bus_rvalid = 1'b0;
      chk("late_rvalid_ignored", dbg_state, ST_IDLE);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit          wr, rd;
    int          m, mode, gap;
    logic [31:0] a;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = '0;

    #12;
    chk("reset_state", dbg_state, ST_IDLE);
    chk("reset_bus_req", bus_req, 1'b0);
    chk("reset_bus_we", bus_we, 1'b0);
    chk("reset_cpu_stall", cpu_stall, 1'b0);
    chk("reset_err_sticky", err_sticky, 1'b0);
    chk("reset_bus_addr", bus_addr, 32'h0);
    chk("reset_bus_wdata", bus_wdata, 32'h0);
    chk("reset_cpu_rdata", cpu_rdata, 32'h0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;

    preload(32'h100, 32'h1234_5678);
    run_access(1'b0, 1'b1, 32'h100, 32'h0, 0, 1, 0);
    run_access(1'b1, 1'b0, 32'h10, 32'hCAFE_F00D, 3, 0, 0);
    run_access(1'b0, 1'b1, 32'h10, 32'h0, 0, 0, 0);

    for (int i = 0; i < 120; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = !wr || ($urandom_range(0, 7) == 0);
      a  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
      m  = $urandom_range(0, 19);
      mode = (m < 14) ? 0 : (m < 17) ? 1 : (m < 19) ? 2 : 3;
      run_access(wr, rd, a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), mode);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end

    run_access(1'b0, 1'b1, 32'h104, 32'h0, 0, 0, 2);
    run_access(1'b0, 1'b1, 32'h108, 32'h0, 1, 0, 3);
    run_access(1'b0, 1'b1, 32'h10C, 32'h0, 0, 0, 4);
    run_access(1'b0, 1'b1, 32'h100, 32'h0, 1, 2, 0);
    run_access(1'b1, 1'b0, 32'h13, 32'h5555_AAAA, 0, 0, 0);
    run_access(1'b0, 1'b1, 32'h10, 32'h0, 2, 1, 0);

    for (int i = 0; i < 60; i++) begin
      wr = 1'($urandom_range(0, 1));
      rd = !wr;
      a  = 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
      mode = ($urandom_range(0, 9) == 0) ? 1 : 0;
      run_access(wr, rd, a, $urandom(), $urandom_range(0, 3), $urandom_range(0, 3), mode);
    end

    repeat (5) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
